// File: rtl/byte_mem_wait.sv
// Byte-addressed little-endian data memory with a req/ready handshake and LAT wait states.
// Optional MEM_WRAP_ERR_EN flags and suppresses accesses whose last byte wraps past the top.
module byte_mem_wait #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int LAT    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] be,
  output logic                ready,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                err
);

  localparam int BYTES = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BYTES-1:0]    be_q;
  logic [DATA_W-1:0]   rd_word;
  logic                commit;
  logic                blocked;

  logic [7:0] mem [2**ADDR_W];

  assign commit = (state == WAIT) && (cnt == '0);
  assign busy   = (state != IDLE);

`ifdef MEM_WRAP_ERR_EN
  logic [ADDR_W:0] end_addr;
  assign end_addr = {1'b0, addr_q} + (ADDR_W+1)'(BYTES - 1);
  assign blocked  = end_addr[ADDR_W];
`else
  assign blocked  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE && req) begin
      cnt <= 4'(LAT);
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

  // Byte indices are ADDR_W wide, so addr_q + i wraps to 0 on its own.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      rd_word[8*i +: 8] = mem[addr_q + ADDR_W'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && we_q && !blocked) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (be_q[i]) mem[addr_q + ADDR_W'(i)] <= wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      ready <= commit;
      err   <= commit && blocked;
      if (commit && !we_q) rdata <= blocked ? '0 : rd_word;
    end
  end

endmodule

// File: tb/tb_byte_mem_wait.sv
// Directed self-checking bench for byte_mem_wait (LAT=3): vector table plus
// hand-written sequences for busy-ignore, mid-access reset and back-to-back reads.
module tb_byte_mem_wait;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LAT    = 3;
`ifdef MEM_WRAP_ERR_EN
  localparam bit WRAP_ERR = 1'b1;
`else
  localparam bit WRAP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [15:0] addr, wdata;
  logic [1:0]  be;
  logic        ready, busy, err;
  logic [15:0] rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  byte_mem_wait #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .ready(ready), .rdata(rdata), .busy(busy), .err(err)
  );

  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    logic [1:0]  b;
    logic [15:0] rd;
    logic        e;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete access; inputs are scrambled right after accept to show they are ignored.
  task automatic access(input string tag, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] b,
                        input logic [15:0] exp_rd, input logic exp_err);
    int   n;
    logic bz;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk); #1;
    bz = busy;
    req = 1'b0; we = ~w; addr = a ^ 16'h5A5A; wdata = ~d; be = ~b;
    n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " busy_after_accept"}, 32'(bz), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(LAT + 1));
    check({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
    check({tag, " err"}, 32'(err), 32'(exp_err));
    check({tag, " busy_in_resp"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    check({tag, " ready_one_cycle"}, 32'(ready), 32'd0);
    check({tag, " idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] hold;
    int k, cyc, last, extra;

    vecs[0] = '{1'b1, 16'h1000, 16'h1234, 2'b11, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 16'h1000, 16'h0000, 2'b00, 16'h1234, 1'b0};
    vecs[2] = '{1'b1, 16'h1000, 16'hABCD, 2'b01, 16'h1234, 1'b0};
    vecs[3] = '{1'b0, 16'h1000, 16'h0000, 2'b11, 16'h12CD, 1'b0};
    vecs[4] = '{1'b1, 16'h1000, 16'h5555, 2'b00, 16'h12CD, 1'b0};
    vecs[5] = '{1'b0, 16'h1000, 16'h0000, 2'b10, 16'h12CD, 1'b0};
    vecs[6] = '{1'b1, 16'h0000, 16'h2211, 2'b11, 16'h12CD, 1'b0};
    vecs[7] = '{1'b1, 16'hFFFF, 16'hBEEF, 2'b11, 16'h12CD, WRAP_ERR};
    vecs[8] = '{1'b0, 16'hFFFF, 16'h0000, 2'b11, WRAP_ERR ? 16'h0000 : 16'hBEEF, WRAP_ERR};
    vecs[9] = '{1'b0, 16'h0000, 16'h0000, 2'b11, WRAP_ERR ? 16'h2211 : 16'h22BE, 1'b0};

    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(ready), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
    check("reset err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      access($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].b,
             vecs[i].rd, vecs[i].e);
    end
    hold = vecs[9].rd;
    check("mem[1000]", 32'(dut.mem[16'h1000]), 32'h0000_00CD);
    check("mem[1001]", 32'(dut.mem[16'h1001]), 32'h0000_0012);
    check("mem[0000]", 32'(dut.mem[16'h0000]), WRAP_ERR ? 32'h11 : 32'hBE);
`ifndef MEM_WRAP_ERR_EN
    check("mem[FFFF]", 32'(dut.mem[16'hFFFF]), 32'h0000_00EF);
`endif

    // Preload words 9..0 at 1000..1012 (step 2)
    for (int i = 0; i < 10; i++) begin
      access($sformatf("pre%0d", i), 1'b1, 16'(16'h1000 + 2 * i), 16'(9 - i), 2'b11, hold, 1'b0);
    end

    // Back-to-back reads with req held high throughout
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 2'b11; addr = 16'h1000;
    k = 0; cyc = 0; last = 0;
    while (k < 10 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (ready) begin
        check($sformatf("stream rdata%0d", k), 32'(rdata), 32'(9 - k));
        if (k > 0) check($sformatf("stream spacing%0d", k), 32'(cyc - last), 32'(LAT + 3));
        last = cyc;
        k++;
        if (k < 10) addr = 16'(16'h1000 + 2 * k);
        else        req = 1'b0;
      end
    end
    req = 1'b0;
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (ready) extra++;
    end
    check("stream pulses", 32'(k), 32'd10);
    check("stream extra pulses", 32'(extra), 32'd0);

    // Request presented while busy must be ignored
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 2'b11; addr = 16'h1000;
    @(posedge clk); #1;
    check("busy_ign E0 busy", 32'(busy), 32'd1);
    check("busy_ign E0 ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    addr = 16'h1002;
    check("busy_ign E1 ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    check("busy_ign E2 ready", 32'(ready), 32'd0);
    check("busy_ign E2 busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("busy_ign E3 ready", 32'(ready), 32'd0);
    @(posedge clk); #1;
    check("busy_ign E4 ready", 32'(ready), 32'd1);
    check("busy_ign E4 rdata", 32'(rdata), 32'h0009);
    req = 1'b0;
    @(posedge clk); #1;
    check("busy_ign after ready", 32'(ready), 32'd0);
    check("busy_ign after busy", 32'(busy), 32'd0);

    // Reset while waiting aborts the write
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 2'b11; addr = 16'h1000; wdata = 16'hFFFF;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wait ready", 32'(ready), 32'd0);
    check("rst_wait busy", 32'(busy), 32'd0);
    check("rst_wait rdata", 32'(rdata), 32'd0);
    check("rst_wait err", 32'(err), 32'd0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("rst_wait mem[1000]", 32'(dut.mem[16'h1000]), 32'h09);
    check("rst_wait mem[1001]", 32'(dut.mem[16'h1001]), 32'h00);

    // Reset on the commit edge discards the write
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 2'b11; addr = 16'h1002; wdata = 16'hFFFF;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_commit ready", 32'(ready), 32'd0);
    check("rst_commit busy", 32'(busy), 32'd0);
    rst = 1'b0;
    check("rst_commit mem[1002]", 32'(dut.mem[16'h1002]), 32'h08);
    check("rst_commit mem[1003]", 32'(dut.mem[16'h1003]), 32'h00);

    access("post_rst read", 1'b0, 16'h1000, 16'h0000, 2'b11, 16'h0009, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
